// File: rtl/id_ctrl_stage_pkg.sv
// Shared decode constants: RV64 opcodes, branch funct3 codes, default widths.
package id_ctrl_stage_pkg;

    localparam int XLEN_DEF = 64;
    localparam int ILEN_DEF = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/id_ctrl_stage_br_cond.sv
// Conditional-branch comparator: decides Bxx taken from operands and funct3.
module id_ctrl_stage_br_cond
    import id_ctrl_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken
);

    // Compare per funct3; reserved codes 010/011 are never taken.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            BR_EQ:   taken = (rs1 == rs2);
            BR_NE:   taken = (rs1 != rs2);
            BR_LT:   taken = ($signed(rs1) <  $signed(rs2));
            BR_GE:   taken = ($signed(rs1) >= $signed(rs2));
            BR_LTU:  taken = (rs1 <  rs2);
            BR_GEU:  taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// Decode-stage front end: fs->ds register, jump/branch resolution with a
// one-shot redirect to fetch, load-use stall, and wrong-path drop filter.
//
// Handshake: a stage transfers on a cycle where the upstream valid and the
// downstream allowin are both high; valid never depends on allowin, and the
// receiving side captures on that edge.
module id_ctrl_stage
    import id_ctrl_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ILEN = ILEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fs_to_ds_valid,
    input  logic [ILEN-1:0] fs_inst,
    input  logic [XLEN-1:0] fs_pc,
    output logic            ds_allowin,
    input  logic            flush,
    input  logic            es_allowin,
    output logic            ds_to_es_valid,
    output logic [XLEN-1:0] ds_pc,
    output logic [ILEN-1:0] ds_inst,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            es_valid,
    input  logic            es_is_load,
    input  logic [4:0]      es_rd,
    output logic            ds_load_block,
    output logic            Is_trans,
    output logic [XLEN-1:0] trans_addr,
    output logic            branch_taken_cancel
);

    logic            ds_valid;
    logic            fired;
    logic            drop_pend;
    logic [XLEN-1:0] tgt_r;

    logic [6:0]      opcode;
    logic            is_jal, is_jalr, is_br;
    logic            uses_rs1, uses_rs2, hit;
    logic            ds_ready_go, br_taken, taken;
    logic [XLEN-1:0] imm_i, imm_b, imm_j, jalr_sum;
    logic            drop_eff, accept;
    logic [XLEN-1:0] tgt_eff;

    assign opcode   = ds_inst[6:0];
    assign rs1_addr = ds_inst[19:15];
    assign rs2_addr = ds_inst[24:20];
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_br    = (opcode == OP_BRANCH);

    assign imm_i = {{(XLEN-12){ds_inst[31]}}, ds_inst[31:20]};
    assign imm_b = {{(XLEN-13){ds_inst[31]}}, ds_inst[31], ds_inst[7],
                    ds_inst[30:25], ds_inst[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){ds_inst[31]}}, ds_inst[31], ds_inst[19:12],
                    ds_inst[20], ds_inst[30:21], 1'b0};
    assign jalr_sum = rs1_data + imm_i;

    id_ctrl_stage_br_cond #(.XLEN(XLEN)) u_br_cond (
        .rs1    (rs1_data),
        .rs2    (rs2_data),
        .funct3 (ds_inst[14:12]),
        .taken  (br_taken)
    );

    // Register-use decode and load-use hazard detection against EX.
    always_comb begin
        uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        uses_rs2 = (opcode == OP_BRANCH || opcode == OP_STORE ||
                    opcode == OP_OP || opcode == OP_OP32);
        hit = (uses_rs1 && rs1_addr == es_rd) || (uses_rs2 && rs2_addr == es_rd);
        ds_load_block = ds_valid & es_valid & es_is_load & (es_rd != 5'd0) & hit;
    end

    assign ds_ready_go    = !ds_load_block;
    assign ds_allowin     = !ds_valid | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid & ds_ready_go & !flush;

    // Redirect target and one-shot strobe; held off while operands are stale.
    always_comb begin
        trans_addr = '0;
        taken      = is_jal | is_jalr | (is_br & br_taken);
        if (is_jal)       trans_addr = ds_pc + imm_j;
        else if (is_jalr) trans_addr = {jalr_sum[XLEN-1:1], 1'b0};
        else if (is_br)   trans_addr = ds_pc + imm_b;
        Is_trans            = ds_valid & ds_ready_go & taken & !fired & !flush;
        branch_taken_cancel = Is_trans;
    end

    // Wrong-path filter; a redirect raised this cycle already applies.
    always_comb begin
        drop_eff = drop_pend | Is_trans;
        tgt_eff  = Is_trans ? trans_addr : tgt_r;
        accept   = fs_to_ds_valid & !flush & !(drop_eff & (fs_pc != tgt_eff));
    end

    // Pipeline register plus redirect bookkeeping; flush overrides all.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ds_valid  <= 1'b0;
            ds_pc     <= '0;
            ds_inst   <= '0;
            fired     <= 1'b0;
            drop_pend <= 1'b0;
            tgt_r     <= '0;
        end else if (flush) begin
            ds_valid  <= 1'b0;
            fired     <= 1'b0;
            drop_pend <= 1'b0;
        end else begin
            if (Is_trans) begin
                fired     <= 1'b1;
                drop_pend <= 1'b1;
                tgt_r     <= trans_addr;
            end
            if (ds_allowin) begin
                ds_valid <= accept;
                if (accept) begin
                    ds_pc     <= fs_pc;
                    ds_inst   <= fs_inst;
                    fired     <= 1'b0;
                    drop_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: redirects, drop filter, load-use, flush, reset.
module tb_id_ctrl_stage;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // Hand-encoded instructions
    localparam logic [31:0] I_NOP  = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] I_BEQ  = 32'h0220_8063; // beq  x1,x2,+0x20
    localparam logic [31:0] I_JALR = 32'hFFF1_00E7; // jalr x1,-1(x2)
    localparam logic [31:0] I_ADD  = 32'h0072_8333; // add  x6,x5,x7
    localparam logic [31:0] I_BLT  = 32'h0020_C463; // blt  x1,x2,+8
    localparam logic [31:0] I_BLTU = 32'h0020_E463; // bltu x1,x2,+8

    logic            clk;
    logic            reset;
    logic            fs_to_ds_valid;
    logic [ILEN-1:0] fs_inst;
    logic [XLEN-1:0] fs_pc;
    logic            ds_allowin;
    logic            flush;
    logic            es_allowin;
    logic            ds_to_es_valid;
    logic [XLEN-1:0] ds_pc;
    logic [ILEN-1:0] ds_inst;
    logic [4:0]      rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            es_valid, es_is_load;
    logic [4:0]      es_rd;
    logic            ds_load_block;
    logic            Is_trans;
    logic [XLEN-1:0] trans_addr;
    logic            branch_taken_cancel;

    int n_cmp;
    int n_err;
    int pulses;

    id_ctrl_stage #(.XLEN(XLEN), .ILEN(ILEN)) dut (
        .clk                 (clk),
        .reset               (reset),
        .fs_to_ds_valid      (fs_to_ds_valid),
        .fs_inst             (fs_inst),
        .fs_pc               (fs_pc),
        .ds_allowin          (ds_allowin),
        .flush               (flush),
        .es_allowin          (es_allowin),
        .ds_to_es_valid      (ds_to_es_valid),
        .ds_pc               (ds_pc),
        .ds_inst             (ds_inst),
        .rs1_addr            (rs1_addr),
        .rs2_addr            (rs2_addr),
        .rs1_data            (rs1_data),
        .rs2_data            (rs2_data),
        .es_valid            (es_valid),
        .es_is_load          (es_is_load),
        .es_rd               (es_rd),
        .ds_load_block       (ds_load_block),
        .Is_trans            (Is_trans),
        .trans_addr          (trans_addr),
        .branch_taken_cancel (branch_taken_cancel)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then changed at posedge+1 and checked at posedge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic v, input logic [63:0] pc, input logic [31:0] inst);
        fs_to_ds_valid = v;
        fs_pc          = pc;
        fs_inst        = inst;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        fetch(1'b0, 64'h0, I_NOP);
        flush = 1'b0; es_allowin = 1'b1;
        es_valid = 1'b0; es_is_load = 1'b0; es_rd = 5'd0;
        rs1_data = '0; rs2_data = '0;

        // Reset state
        #2;
        check("rst_ds_to_es_valid", 64'(ds_to_es_valid), 64'd0);
        check("rst_allowin",        64'(ds_allowin),     64'd1);
        check("rst_is_trans",       64'(Is_trans),       64'd0);
        check("rst_ds_pc",          ds_pc,               64'h0);
        check("rst_ds_inst",        64'(ds_inst),        64'h0);
        check("rst_trans_addr",     trans_addr,          64'h0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // BEQ taken, wrong path dropped, target captured
        fetch(1'b1, 64'h8000_0010, I_BEQ);
        tick();
        rs1_data = 64'd5; rs2_data = 64'd5;
        fetch(1'b1, 64'h8000_0014, I_NOP);
        #1;
        check("beq_is_trans",    64'(Is_trans),            64'd1);
        check("beq_cancel",      64'(branch_taken_cancel), 64'd1);
        check("beq_trans_addr",  trans_addr,               64'h8000_0030);
        check("beq_to_es",       64'(ds_to_es_valid),      64'd1);
        tick();
        fetch(1'b1, 64'h8000_0018, I_NOP);
        #1;
        check("beq_drop1_valid", 64'(ds_to_es_valid), 64'd0);
        check("beq_drop1_trans", 64'(Is_trans),       64'd0);
        check("beq_drop1_allow", 64'(ds_allowin),     64'd1);
        tick();
        fetch(1'b1, 64'h8000_0030, I_NOP);
        #1;
        check("beq_drop2_valid", 64'(ds_to_es_valid), 64'd0);
        tick();
        fetch(1'b1, 64'h8000_0034, I_NOP);
        #1;
        check("beq_tgt_valid",   64'(ds_to_es_valid), 64'd1);
        check("beq_tgt_pc",      ds_pc,               64'h8000_0030);
        tick();
        fetch(1'b0, 64'h0, I_NOP);
        #1;
        check("beq_after_pc",    ds_pc,               64'h8000_0034);

        // JALR with EX stalled: single redirect pulse
        fetch(1'b1, 64'h8000_0100, I_JALR);
        tick();
        fetch(1'b0, 64'h0, I_NOP);
        rs1_data = 64'h8000_1001;
        es_allowin = 1'b0;
        pulses = 0;
        #1;
        check("jalr_trans_addr", trans_addr, 64'h8000_1000);
        for (int i = 0; i < 3; i++) begin
            if (Is_trans) pulses++;
            check("jalr_stall_allow", 64'(ds_allowin), 64'd0);
            tick();
            #1;
        end
        check("jalr_pulses", 64'(pulses), 64'd1);
        es_allowin = 1'b1;
        #1;
        check("jalr_release_trans", 64'(Is_trans), 64'd0);
        tick();
        fetch(1'b1, 64'h8000_1000, I_NOP);
        tick();
        fetch(1'b1, 64'h8000_1004, I_ADD);
        #1;
        check("jalr_tgt_pc", ds_pc, 64'h8000_1000);
        tick();

        // Load-use on ADD x6,x5,x7
        fetch(1'b0, 64'h0, I_NOP);
        es_valid = 1'b1; es_is_load = 1'b1; es_rd = 5'd5;
        #1;
        check("lu_rs1_block",  64'(ds_load_block),  64'd1);
        check("lu_rs1_to_es",  64'(ds_to_es_valid), 64'd0);
        check("lu_rs1_allow",  64'(ds_allowin),     64'd0);
        es_rd = 5'd7;
        #1;
        check("lu_rs2_block",  64'(ds_load_block),  64'd1);
        es_rd = 5'd0;
        #1;
        check("lu_x0_block",   64'(ds_load_block),  64'd0);
        check("lu_x0_to_es",   64'(ds_to_es_valid), 64'd1);
        es_rd = 5'd6;
        #1;
        check("lu_rd_block",   64'(ds_load_block),  64'd0);
        es_valid = 1'b0; es_is_load = 1'b0; es_rd = 5'd0;
        tick();

        // BLT signed taken / BLTU unsigned not taken
        fetch(1'b1, 64'h8000_2000, I_BLT);
        tick();
        fetch(1'b0, 64'h0, I_NOP);
        rs1_data = 64'hFFFF_FFFF_FFFF_FFFF; rs2_data = 64'd1;
        #1;
        check("blt_is_trans",   64'(Is_trans), 64'd1);
        check("blt_trans_addr", trans_addr,    64'h8000_2008);
        tick();
        fetch(1'b1, 64'h8000_2008, I_NOP);
        tick();
        fetch(1'b1, 64'h8000_200C, I_BLTU);
        tick();
        fetch(1'b1, 64'h8000_2010, I_NOP);
        #1;
        check("bltu_is_trans",  64'(Is_trans),       64'd0);
        check("bltu_to_es",     64'(ds_to_es_valid), 64'd1);
        tick();
        fetch(1'b0, 64'h0, I_NOP);
        #1;
        check("bltu_next_pc",   ds_pc, 64'h8000_2010);

        // Flush while a redirect drop is pending and ds holds a stalled branch
        fetch(1'b1, 64'h8000_3000, I_BEQ);
        rs1_data = 64'd5; rs2_data = 64'd5;
        tick();
        fetch(1'b0, 64'h0, I_NOP);
        es_allowin = 1'b0;
        #1;
        check("fl_is_trans",    64'(Is_trans), 64'd1);
        tick();
        flush = 1'b1;
        #1;
        check("fl_to_es",       64'(ds_to_es_valid), 64'd0);
        check("fl_trans",       64'(Is_trans),       64'd0);
        tick();
        flush = 1'b0; es_allowin = 1'b1;
        fetch(1'b1, 64'h9000_0000, I_NOP);
        #1;
        check("fl_empty",       64'(ds_to_es_valid), 64'd0);
        tick();
        fetch(1'b0, 64'h0, I_NOP);
        #1;
        check("fl_capture_valid", 64'(ds_to_es_valid), 64'd1);
        check("fl_capture_pc",    ds_pc,               64'h9000_0000);
        tick();

        // Reset asserted mid-stream with a redirect in progress
        fetch(1'b1, 64'h8000_4000, I_BEQ);
        tick();
        fetch(1'b0, 64'h0, I_NOP);
        #1;
        check("mr_pre_trans", 64'(Is_trans), 64'd1);
        reset = 1'b1;
        #1;
        check("mr_to_es", 64'(ds_to_es_valid), 64'd0);
        check("mr_trans", 64'(Is_trans),       64'd0);
        check("mr_allow", 64'(ds_allowin),     64'd1);
        check("mr_pc",    ds_pc,               64'h0);
        tick();
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
